// File: rtl/traffic_light_pkg.sv
// Shared encodings for the traffic light monitor: lights bus values, tracked phases, error codes.
// Pure definitions and combinational helpers; no state, no latency, no flow control.
package traffic_light_pkg;

    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_e;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL = 3'd1;
    localparam logic [2:0] ERR_ORDER   = 3'd2;
    localparam logic [2:0] ERR_SHORT   = 3'd3;
    localparam logic [2:0] ERR_LONG    = 3'd4;

    function automatic phase_e next_phase(input phase_e cur);
        case (cur)
            PH_RED:    next_phase = PH_GREEN;
            PH_GREEN:  next_phase = PH_YELLOW;
            PH_YELLOW: next_phase = PH_RED;
            default:   next_phase = PH_SYNC;
        endcase
    endfunction

    // Non-one-hot values (including 000) map to SYNC, which doubles as "illegal".
    function automatic phase_e lights_to_phase(input logic [2:0] l);
        case (l)
            LT_RED:    lights_to_phase = PH_RED;
            LT_GREEN:  lights_to_phase = PH_GREEN;
            LT_YELLOW: lights_to_phase = PH_YELLOW;
            default:   lights_to_phase = PH_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/tl_phase_counter.sv
// Saturating phase-length counter with clear/load-1 and MIN/MAX compare flags.
// Count updates one cycle after a command; compare flags are combinational on the held count.
module tl_phase_counter #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_load1,
    input  logic             i_inc,
    input  logic [LEN_W-1:0] i_min,
    input  logic [LEN_W-1:0] i_max,
    output logic [LEN_W-1:0] o_len,
    output logic             o_short,
    output logic             o_long_hit
);

    logic [LEN_W-1:0] r_len;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_len <= '0;
        end else if (i_load1) begin
            r_len <= LEN_W'(1);
        end else if (i_inc && (r_len != '1)) begin
            r_len <= r_len + LEN_W'(1);
        end
    end

    assign o_len      = r_len;
    assign o_short    = (r_len < i_min);
    // Another sample of the same phase will take the length to MAX+1.
    assign o_long_hit = (r_len == i_max);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the RED->GREEN->YELLOW light sequence and per-phase lengths.
// All outputs registered (decision on the sample at edge N visible after edge N); never stalls the bus.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_MIN   = 5,
    parameter int RED_MAX   = 20,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 20,
    parameter int YEL_MIN   = 2,
    parameter int YEL_MAX   = 10,
    parameter int LEN_W     = 16,
    parameter int CYC_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       lights,
    output logic [1:0]       phase,
    output logic             phase_done,
    output logic [LEN_W-1:0] phase_len,
    output logic             err_pulse,
    output logic [2:0]       err_code,
    output logic [2:0]       first_err,
    output logic [7:0]       err_count,
    output logic [CYC_W-1:0] cycle_count
);

    phase_e           r_phase;
    logic             r_chk;
    logic             r_long_flag;
    logic             r_phase_done;
    logic [LEN_W-1:0] r_phase_len;
    logic             r_err_pulse;
    logic [2:0]       r_err_code;
    logic [2:0]       r_first_err;
    logic [7:0]       r_err_count;
    logic [CYC_W-1:0] r_cycle_count;

    phase_e           w_obs;
    phase_e           w_phase_n;
    logic             w_chk_n;
    logic             w_long_flag_n;
    logic [2:0]       w_err;
    logic             w_done;
    logic             w_clr;
    logic             w_load1;
    logic             w_inc;
    logic             w_cyc_inc;
    logic [LEN_W-1:0] w_min;
    logic [LEN_W-1:0] w_max;
    logic [LEN_W-1:0] w_len;
    logic             w_short;
    logic             w_long_hit;

    tl_phase_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_load1    (w_load1),
        .i_inc      (w_inc),
        .i_min      (w_min),
        .i_max      (w_max),
        .o_len      (w_len),
        .o_short    (w_short),
        .o_long_hit (w_long_hit)
    );

    assign w_obs = lights_to_phase(lights);

    always_comb begin
        w_min = '0;
        w_max = '1;
        case (r_phase)
            PH_RED:    begin w_min = LEN_W'(RED_MIN);   w_max = LEN_W'(RED_MAX);   end
            PH_GREEN:  begin w_min = LEN_W'(GREEN_MIN); w_max = LEN_W'(GREEN_MAX); end
            PH_YELLOW: begin w_min = LEN_W'(YEL_MIN);   w_max = LEN_W'(YEL_MAX);   end
            default:   ;
        endcase
    end

    always_comb begin
        w_phase_n     = r_phase;
        w_chk_n       = r_chk;
        w_long_flag_n = r_long_flag;
        w_err         = ERR_NONE;
        w_done        = 1'b0;
        w_clr         = 1'b0;
        w_load1       = 1'b0;
        w_inc         = 1'b0;
        w_cyc_inc     = 1'b0;
        if (r_phase == PH_SYNC) begin
            if (w_obs != PH_SYNC) begin
                // First phase may be partial, so it is tracked but not timed.
                w_phase_n     = w_obs;
                w_chk_n       = 1'b0;
                w_long_flag_n = 1'b0;
                w_load1       = 1'b1;
            end else begin
                w_err = ERR_ILLEGAL;
            end
        end else if (w_obs == PH_SYNC) begin
            w_done    = 1'b1;
            w_err     = ERR_ILLEGAL;
            w_phase_n = PH_SYNC;
            w_clr     = 1'b1;
        end else if (w_obs == r_phase) begin
            w_inc = 1'b1;
            if (r_chk && w_long_hit && !r_long_flag) begin
                w_err         = ERR_LONG;
                w_long_flag_n = 1'b1;
            end
        end else begin
            w_done        = 1'b1;
            w_phase_n     = w_obs;
            w_chk_n       = 1'b1;
            w_long_flag_n = 1'b0;
            w_load1       = 1'b1;
            if (w_obs == next_phase(r_phase)) begin
                if (r_chk && w_short) begin
                    w_err = ERR_SHORT;
                end
                w_cyc_inc = (r_phase == PH_YELLOW);
            end else begin
                w_err = ERR_ORDER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase       <= PH_SYNC;
            r_chk         <= 1'b0;
            r_long_flag   <= 1'b0;
            r_phase_done  <= 1'b0;
            r_phase_len   <= '0;
            r_err_pulse   <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_first_err   <= ERR_NONE;
            r_err_count   <= '0;
            r_cycle_count <= '0;
        end else begin
            r_phase      <= w_phase_n;
            r_chk        <= w_chk_n;
            r_long_flag  <= w_long_flag_n;
            r_phase_done <= w_done;
            if (w_done) begin
                r_phase_len <= w_len;
            end
            r_err_pulse <= (w_err != ERR_NONE);
            if (w_err != ERR_NONE) begin
                r_err_code <= w_err;
                if (r_first_err == ERR_NONE) begin
                    r_first_err <= w_err;
                end
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
            if (w_cyc_inc) begin
                r_cycle_count <= r_cycle_count + CYC_W'(1);
            end
        end
    end

    assign phase       = r_phase;
    assign phase_done  = r_phase_done;
    assign phase_len   = r_phase_len;
    assign err_pulse   = r_err_pulse;
    assign err_code    = r_err_code;
    assign first_err   = r_first_err;
    assign err_count   = r_err_count;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk;
    logic        reset;
    logic [2:0]  lights;
    logic [1:0]  phase;
    logic        phase_done;
    logic [15:0] phase_len;
    logic        err_pulse;
    logic [2:0]  err_code;
    logic [2:0]  first_err;
    logic [7:0]  err_count;
    logic [15:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run accumulators filled by step()
    int n_err;
    int n_done;
    int last_code;
    int last_err_idx;
    int last_len;
    int done_q[$];

    traffic_light_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .lights      (lights),
        .phase       (phase),
        .phase_done  (phase_done),
        .phase_len   (phase_len),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .first_err   (first_err),
        .err_count   (err_count),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_acc();
        n_err = 0;
        n_done = 0;
        last_code = 0;
        last_err_idx = 0;
        last_len = 0;
        done_q.delete();
    endtask

    task automatic step(input logic [2:0] v, input int idx);
        lights = v;
        @(posedge clk);
        #1;
        if (err_pulse === 1'b1) begin
            n_err++;
            last_code = int'(err_code);
            last_err_idx = idx;
        end
        if (phase_done === 1'b1) begin
            n_done++;
            last_len = int'(phase_len);
            done_q.push_back(int'(phase_len));
        end
    endtask

    task automatic drive(input logic [2:0] v, input int n);
        for (int k = 1; k <= n; k++) step(v, k);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_phase"}, 32'(phase), 0);
        check_eq({tag, "_done"}, 32'(phase_done), 0);
        check_eq({tag, "_len"}, 32'(phase_len), 0);
        check_eq({tag, "_errp"}, 32'(err_pulse), 0);
        check_eq({tag, "_code"}, 32'(err_code), 0);
        check_eq({tag, "_first"}, 32'(first_err), 0);
        check_eq({tag, "_cnt"}, 32'(err_count), 0);
        check_eq({tag, "_cyc"}, 32'(cycle_count), 0);
    endtask

    initial begin
        int exp_lens[9] = '{10, 8, 3, 10, 8, 3, 10, 8, 3};
        reset = 1'b1;
        lights = 3'b000;
        clr_acc();
        drive(3'b000, 2);
        check_all_zero("reset");
        reset = 1'b0;

        // Clean loops: first RED unchecked, then three R/G/Y cycles
        clr_acc();
        drive(R, 10);
        for (int l = 0; l < 3; l++) begin
            drive(G, 8);
            drive(Y, 3);
            drive(R, 10);
        end
        check_eq("clean_errs", 32'(n_err), 0);
        check_eq("clean_first", 32'(first_err), 0);
        check_eq("clean_cyc", 32'(cycle_count), 3);
        check_eq("clean_ndone", 32'(n_done), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < done_q.size()) check_eq($sformatf("clean_len%0d", i), 32'(done_q[i]), 32'(exp_lens[i]));
        end
        check_eq("clean_phase", 32'(phase), 1);

        // Short yellow
        clr_acc();
        drive(G, 8);
        drive(Y, 1);
        check_eq("sy_pre_errs", 32'(n_err), 0);
        step(R, 1);
        check_eq("sy_done", 32'(phase_done), 1);
        check_eq("sy_len", 32'(phase_len), 1);
        check_eq("sy_errp", 32'(err_pulse), 1);
        check_eq("sy_code", 32'(err_code), 3);
        check_eq("sy_first", 32'(first_err), 3);
        check_eq("sy_cnt", 32'(err_count), 1);
        check_eq("sy_cyc", 32'(cycle_count), 4);
        drive(R, 9);

        // Order violation from a short GREEN: ORDER wins over SHORT
        clr_acc();
        drive(G, 3);
        step(R, 1);
        check_eq("ord_code", 32'(err_code), 2);
        check_eq("ord_errp", 32'(err_pulse), 1);
        check_eq("ord_phase", 32'(phase), 1);
        check_eq("ord_len", 32'(phase_len), 3);
        check_eq("ord_cnt", 32'(err_count), 2);
        check_eq("ord_first", 32'(first_err), 3);
        check_eq("ord_cyc", 32'(cycle_count), 4);
        clr_acc();
        drive(R, 9);
        drive(G, 8);
        drive(Y, 3);
        drive(R, 10);
        check_eq("ord_after_errs", 32'(n_err), 0);
        check_eq("ord_after_cyc", 32'(cycle_count), 5);

        // Illegal encoding mid-RED
        clr_acc();
        step(3'b110, 1);
        check_eq("ill_code", 32'(err_code), 1);
        check_eq("ill_phase", 32'(phase), 0);
        check_eq("ill_done", 32'(phase_done), 1);
        check_eq("ill_len", 32'(phase_len), 10);
        check_eq("ill_cnt", 32'(err_count), 3);
        clr_acc();
        drive(R, 3);
        drive(G, 2);
        check_eq("ill_resync_errs", 32'(n_err), 0);
        check_eq("ill_resync_len", 32'(last_len), 3);
        clr_acc();
        drive(Y, 3);
        check_eq("ill_chk_errs", 32'(n_err), 1);
        check_eq("ill_chk_code", 32'(last_code), 3);
        check_eq("ill_chk_idx", 32'(last_err_idx), 1);
        clr_acc();
        drive(R, 10);
        check_eq("ill_red_errs", 32'(n_err), 0);
        check_eq("ill_cyc", 32'(cycle_count), 6);

        // Long green: one LONG on the 21st sample
        clr_acc();
        drive(G, 25);
        check_eq("long_errs", 32'(n_err), 1);
        check_eq("long_code", 32'(last_code), 4);
        check_eq("long_idx", 32'(last_err_idx), 21);
        clr_acc();
        step(Y, 1);
        check_eq("long_done", 32'(phase_done), 1);
        check_eq("long_len", 32'(phase_len), 25);
        check_eq("long_exit_errp", 32'(err_pulse), 0);
        check_eq("long_cnt", 32'(err_count), 5);
        drive(Y, 2);
        drive(R, 10);
        check_eq("long_cyc", 32'(cycle_count), 7);

        // Reset mid-GREEN at len 6
        drive(G, 6);
        reset = 1'b1;
        step(G, 1);
        check_all_zero("midrst");
        reset = 1'b0;
        clr_acc();
        drive(G, 2);
        drive(Y, 3);
        check_eq("midrst_errs", 32'(n_err), 0);
        check_eq("midrst_len", 32'(done_q.size() > 0 ? done_q[0] : -1), 2);

        // Exact MIN and MAX lengths on every phase are legal
        clr_acc();
        drive(R, 20);
        drive(G, 20);
        drive(Y, 2);
        drive(R, 5);
        drive(G, 5);
        drive(Y, 10);
        drive(R, 1);
        check_eq("bound_errs", 32'(n_err), 0);
        check_eq("bound_cnt", 32'(err_count), 0);
        check_eq("bound_cyc", 32'(cycle_count), 3);
        check_eq("bound_len", 32'(last_len), 10);

        // Error counter saturation with persistent 000 in SYNC
        reset = 1'b1;
        step(3'b000, 1);
        reset = 1'b0;
        clr_acc();
        drive(3'b000, 260);
        check_eq("sat_errs", 32'(n_err), 260);
        check_eq("sat_cnt", 32'(err_count), 255);
        check_eq("sat_errp", 32'(err_pulse), 1);
        check_eq("sat_code", 32'(err_code), 1);
        check_eq("sat_first", 32'(first_err), 1);
        check_eq("sat_ndone", 32'(n_done), 0);
        check_eq("sat_phase", 32'(phase), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the 3-bit `lights` bus driven by the traffic light controller; the consuming end of that interface.
- Samples `lights` every clock and tracks the phase sequence RED -> GREEN -> YELLOW -> RED.
- Measures each phase length in cycles, checks it against min/max bounds, and flags encoding, ordering and timing violations.
- Instantiated beside the controller in benches and in system-level self-check builds.

Parameters:
- RED_MIN, 5, minimum legal RED length in cycles
- RED_MAX, 20, maximum legal RED length in cycles
- GREEN_MIN, 5, minimum legal GREEN length in cycles
- GREEN_MAX, 20, maximum legal GREEN length in cycles
- YEL_MIN, 2, minimum legal YELLOW length in cycles
- YEL_MAX, 10, maximum legal YELLOW length in cycles
- LEN_W, 16, width of the phase-length counter (saturating)
- CYC_W, 16, width of the completed-cycle counter (wraps)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- lights  input  3  [2]=red, [1]=yellow, [0]=green; legal values 100, 010, 001 only
- phase  output  2  current tracked phase: 0 SYNC, 1 RED, 2 GREEN, 3 YELLOW
- phase_done  output  1  one-cycle pulse when a phase ends
- phase_len  output  LEN_W  length of the phase that just ended; valid while phase_done=1
- err_pulse  output  1  one-cycle pulse per detected error
- err_code  output  3  code of the error in the current err_pulse cycle; holds its value otherwise
- first_err  output  3  sticky code of the first error since reset
- err_count  output  8  saturating error count (stops at 255)
- cycle_count  output  CYC_W  count of legal YELLOW->RED transitions

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0; FSM goes to SYNC; the length counter clears.
  - Reset mid-phase has the same effect; no error is reported for the truncated phase.
- Outputs are registered: a decision made on the sample at edge N is visible after edge N.
- Error codes, priority highest first; at most one code per cycle:
  - 1 ILLEGAL: `lights` not one-hot, including 000
  - 2 ORDER: transition out of sequence
  - 3 SHORT: phase ended below its MIN
  - 4 LONG: phase exceeded its MAX
- FSM states: SYNC, RED, GREEN, YELLOW.
- SYNC state:
  - Waits for the first legal one-hot value and enters that phase with len=1.
  - chk=0 for this first phase: it may be partial, so neither MIN nor MAX is checked and it ends with no SHORT/LONG.
  - Illegal values in SYNC raise ILLEGAL every cycle they persist.
- Phase states, per sample:
  - Same value: len <= len+1, saturating at all-ones.
    - If chk=1 and len+1 == MAX+1, raise LONG once. A per-phase flag suppresses repeats.
  - Next legal phase in sequence:
    - Pulse phase_done with phase_len=len.
    - If chk=1 and len < MIN, raise SHORT.
    - Enter the new phase with len=1 and chk=1.
    - If this is a YELLOW->RED transition, increment cycle_count (wraps modulo 2^CYC_W).
  - Legal but out-of-order value:
    - Pulse phase_done with phase_len=len.
    - Raise ORDER only; SHORT is suppressed by priority.
    - Enter the observed phase with chk=1, so the monitor resynchronises on it.
  - Illegal value:
    - Pulse phase_done with phase_len=len.
    - Raise ILLEGAL and go to SYNC.
- Error bookkeeping:
  - first_err latches only while it is 0.
  - err_count saturates at 255; err_pulse still fires when saturated.
- Boundary lengths:
  - len == MIN is legal; len == MAX is legal.
  - LONG fires on the sample that makes len MAX+1.

Decomposition:
- Package `traffic_light_pkg` holds:
  - lights encodings: LT_RED=3'b100, LT_YELLOW=3'b010, LT_GREEN=3'b001
  - phase/FSM state encodings
  - error code constants
  - a next-phase lookup function
- One sub-module, `tl_phase_counter`: a saturating LEN_W counter with clear/load-1, plus min/max compare producing `short` and `long_hit` flags. MIN/MAX are selected by the current phase in the parent.

Test Plan:
- Clean loop: RED 10, GREEN 8, YELLOW 3 cycles, 3 loops after reset.
  -> No err_pulse; first_err=0.
  -> phase_done with phase_len 8, 3, 10 after the first (unchecked) phase.
  -> cycle_count=3.
- Short yellow: GREEN 8 then YELLOW 1 then RED.
  -> At RED entry: phase_done with phase_len=1, err_pulse, err_code=3, first_err=3, err_count=1.
- Order violation: GREEN 8 then RED.
  -> err_code=2 only, no SHORT; phase=RED.
  -> The following GREEN 8 / YELLOW 3 produce no error.
- Illegal encoding: lights=3'b110 for 1 cycle during RED.
  -> err_code=1, phase=SYNC.
  -> The next RED is unchecked; later phases are checked normally.
- Long green: GREEN held 25 cycles.
  -> Exactly one err_code=4 pulse, on the 21st GREEN sample.
  -> phase_done at exit with phase_len=25.
- Reset mid-GREEN at len 6.
  -> All outputs 0 and phase=SYNC after the edge.
  -> The next observed phase is unchecked; no error for a short first phase.
